// File: rtl/io_timer_responder_if.sv
// CPU data-port bundle for the timer responder: request fields in, status out.
// No storage; pure signal grouping.
// The master drives start and the request fields, and the slave reports busy.
interface io_timer_responder_if;
   logic        start;
   logic        wea;
   logic [31:0] addr;
   logic [31:0] in_data;
   logic [2:0]  rol;
   logic        busy;
   logic [31:0] out_data;
   logic        irq;
   logic        err;

   modport master (
      output start, wea, addr, in_data, rol,
      input  busy, out_data, irq, err
   );

   modport slave (
      input  start, wea, addr, in_data, rol,
      output busy, out_data, irq, err
   );
endinterface

// File: rtl/io_timer_responder.sv
// Memory-mapped timer (CTRL/COUNT/COMPARE/STATUS) behind a fixed-latency CPU port.
// Latency: busy for WAIT_CYCLES cycles after start; write commit and read data on the busy-falling edge.
// Backpressure: start is ignored while a transaction is in flight; the CPU watches busy.
module io_timer_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   io_timer_responder_if.slave   bus
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q;
   logic        accept, last;

   logic        req_wea;
   logic [31:0] req_addr, req_data;
   logic [2:0]  req_rol;

   logic [2:0]  ctrl_q;
   logic [31:0] count_q, compare_q, out_q;
   logic        match_q, err_q;

   logic        is_byte, is_half, sext, hit, misal, bad;
   logic [4:0]  sh;
   logic [31:0] rd_reg, rd_shift, rd_val, wr_mask, wr_pos;
   logic        wr_ctrl, wr_count, wr_compare, wr_status;
   logic [31:0] ctrl_merged;
   logic        match_evt;
   logic [1:0]  clr;

   assign accept = (state_q == ST_IDLE) && bus.start;
   assign last   = (state_q == ST_WAIT) && (wcnt_q == 4'd0);

   // FSM state register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next state: leave IDLE on start, return after the last busy cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_WAIT;
         ST_WAIT: if (wcnt_q == 4'd0) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Busy-cycle countdown and request capture in the accepting cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q   <= 4'd0;
         req_wea  <= 1'b0;
         req_addr <= 32'd0;
         req_data <= 32'd0;
         req_rol  <= 3'd0;
      end else if (accept) begin
         wcnt_q   <= WAIT_LAST;
         req_wea  <= bus.wea;
         req_addr <= bus.addr;
         req_data <= bus.in_data;
         req_rol  <= bus.rol;
      end else if (state_q == ST_WAIT && wcnt_q != 4'd0) begin
         wcnt_q <= wcnt_q - 4'd1;
      end
   end

   // Address/size decode, lane steering for reads and writes
   always_comb begin
      is_byte = (req_rol == 3'b001) || (req_rol == 3'b010);
      is_half = (req_rol == 3'b011) || (req_rol == 3'b100);
      sext    = (req_rol == 3'b010) || (req_rol == 3'b100);
      hit     = (req_addr[31:4] == BASE_ADDR[31:4]);
      misal   = (is_half && req_addr[0]) ||
                (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
      bad     = !hit || misal;
      sh      = 5'd0;
      wr_mask = 32'hFFFF_FFFF;
      if (is_byte) begin
         sh      = {req_addr[1:0], 3'b000};
         wr_mask = 32'h0000_00FF << sh;
      end else if (is_half) begin
         sh      = {req_addr[1], 4'b0000};
         wr_mask = 32'h0000_FFFF << sh;
      end
      case (req_addr[3:2])
         2'd0:    rd_reg = {29'd0, ctrl_q};
         2'd1:    rd_reg = count_q;
         2'd2:    rd_reg = compare_q;
         default: rd_reg = {30'd0, err_q, match_q};
      endcase
      rd_shift = rd_reg >> sh;
      if (is_byte)
         rd_val = sext ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'd0, rd_shift[7:0]};
      else if (is_half)
         rd_val = sext ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'd0, rd_shift[15:0]};
      else
         rd_val = rd_shift;
      if (bad) rd_val = 32'd0;
      wr_pos     = (req_data << sh) & wr_mask;
      wr_ctrl    = last && req_wea && !bad && (req_addr[3:2] == 2'd0);
      wr_count   = last && req_wea && !bad && (req_addr[3:2] == 2'd1);
      wr_compare = last && req_wea && !bad && (req_addr[3:2] == 2'd2);
      wr_status  = last && req_wea && !bad && (req_addr[3:2] == 2'd3);
      ctrl_merged = ({29'd0, ctrl_q} & ~wr_mask) | wr_pos;
      clr        = wr_status ? wr_pos[1:0] : 2'b00;
      match_evt  = ctrl_q[0] && (count_q == compare_q);
   end

   // Register file and timer; CPU writes override the counter, new events override W1C
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q    <= 3'd0;
         count_q   <= 32'd0;
         compare_q <= 32'hFFFF_FFFF;
         match_q   <= 1'b0;
         err_q     <= 1'b0;
         out_q     <= 32'd0;
      end else begin
         if (wr_count)
            count_q <= (count_q & ~wr_mask) | wr_pos;
         else if (ctrl_q[0])
            count_q <= (match_evt && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
         if (wr_ctrl)    ctrl_q    <= ctrl_merged[2:0];
         if (wr_compare) compare_q <= (compare_q & ~wr_mask) | wr_pos;
         match_q <= (match_q && !clr[0]) || match_evt;
         err_q   <= (err_q && !clr[1]) || (last && bad);
         if (last) out_q <= req_wea ? 32'd0 : rd_val;
      end
   end

   assign bus.busy     = (state_q == ST_WAIT);
   assign bus.out_data = out_q;
   assign bus.irq      = match_q && ctrl_q[1];
   assign bus.err      = err_q;

endmodule

// File: doc/io_timer_responder.md
IO_TIMER_RESPONDER -- requirements
Module: io_timer_responder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h1001_0000, byte address of the 16-byte register window (bits [3:0] zero).
REQ-002 Parameter: WAIT_CYCLES, 2, busy cycles per transaction (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 start  input  1  one-cycle transaction request from the CPU data port.
REQ-006 wea  input  1  1 = write, 0 = read; sampled with start.
REQ-007 addr  input  32  byte address; sampled with start.
REQ-008 in_data  input  32  write data, right-justified; sampled with start.
REQ-009 rol  input  3  access size: 000 word, 001 byte zero-extend, 010 byte sign-extend, 011 half zero-extend, 100 half sign-extend, 101-111 treated as word.
REQ-010 busy  output  1  high while a transaction is in progress.
REQ-011 out_data  output  32  read result, valid from busy falling edge until the next accepted start.
REQ-012 irq  output  1  level interrupt = STATUS.match AND CTRL.irq_en.
REQ-013 err  output  1  sticky bus-error flag.

Function
REQ-014 Registers by addr[3:2]: 0 CTRL (bit0 enable, bit1 irq_en, bit2 auto_reload, others read 0), 1 COUNT, 2 COMPARE, 3 STATUS (bit0 match, bit1 err; write-1-to-clear).
REQ-015 States: IDLE, WAIT; IDLE->WAIT when start=1; WAIT->IDLE after exactly WAIT_CYCLES cycles.
REQ-016 Request fields are latched in the start cycle; busy rises the cycle after start and stays high for WAIT_CYCLES cycles.
REQ-017 start while busy=1, or in the cycle busy falls, is ignored with no state change.
REQ-018 Write commit and out_data update occur on the last WAIT cycle edge, coincident with busy falling.
REQ-019 Byte access uses lane addr[1:0]; halfword access uses lane addr[1]; reads shift selected lane to bit 0 then zero/sign-extend per rol.
REQ-020 Byte/half writes merge into the selected lane only; other bytes of the register are preserved.
REQ-021 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): write has no effect, read returns 0, err sets.
REQ-022 addr[31:4] != BASE_ADDR[31:4]: write ignored, read returns 0, err sets; handshake timing unchanged.
REQ-023 CTRL.enable=1: COUNT increments by 1 per cycle, wrapping 32'hFFFF_FFFF -> 0.
REQ-024 COUNT == COMPARE while enabled sets STATUS.match on the next edge; if auto_reload=1, COUNT loads 0 on that same edge instead of incrementing.
REQ-025 Simultaneous CPU write to COUNT and increment/reload: CPU write value wins.
REQ-026 Simultaneous W1C of match and new match event: match remains 1.
REQ-027 Simultaneous W1C of STATUS.err and new error on same access: err remains 1.
REQ-028 err output mirrors STATUS.err; irq is combinational from registers, no extra latency.

Reset
REQ-029 rst=0 forces at once: state IDLE, busy 0, out_data 0, CTRL 0, COUNT 0, COMPARE 32'hFFFF_FFFF, STATUS 0, irq 0, err 0.
REQ-030 rst asserted mid-transaction aborts it: no write commits, busy drops immediately, no out_data update.
REQ-031 First start is accepted on the first rising edge after rst returns to 1.

Verification
REQ-032 Word write COMPARE=5, CTRL=1 -> busy high 2 cycles after start; COUNT reaches 5, match=1 next edge, irq=0; write CTRL=3 -> irq=1.
REQ-033 COUNT=32'h0000_80FF; read byte addr BASE+5 rol=010 -> out_data 32'hFFFF_FF80; rol=001 -> 32'h0000_0080; half BASE+6 rol=100 -> 32'h0000_0000.
REQ-034 Byte write 8'hAB to BASE+9 with COMPARE=32'h1122_3344 -> COMPARE=32'h1122_AB44.
REQ-035 Read BASE+2 rol=000 -> out_data 0, err=1; read 0x2000_0000 -> out_data 0, err=1; W1C STATUS bit1 -> err=0.
REQ-036 start pulsed again during busy -> ignored, busy still exactly WAIT_CYCLES cycles; rst=0 in first WAIT cycle of COUNT write -> COUNT stays 0, busy 0 immediately.
REQ-037 auto_reload=1, COMPARE=3 -> COUNT sequence 0,1,2,3,0,1; W1C match in the cycle of new match -> match stays 1.
